ex_hazard_ctrl: RTL and testbench

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

---
 rtl/ex_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use bubbles and a
// RUN/BUSY FSM that stalls the pipe for a multi-cycle unit with a timeout.
module ex_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic [4:0]  id_ex_rs1,
  input  logic [4:0]  id_ex_rs2,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_reg_write,
  input  logic [4:0]  mem_wb_rd,
  input  logic        mem_wb_reg_write,
  input  logic        mdu_start,
  input  logic        mdu_done,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic        mdu_busy,
  output logic        mdu_timeout,
  output logic [31:0] stall_cycles
);

  localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);

  typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   wait_cnt;
  logic            timeout_q;
  logic [31:0]     stall_q;
  logic            timeout_hit;
  logic            mdu_stall;
  logic            load_use;

  // EX/MEM result is younger than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
      return 2'b10;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    state_nxt     = state;
    timeout_hit   = 1'b0;
    mdu_stall     = 1'b0;
    load_use      = 1'b0;
    forward_a     = 2'b00;
    forward_b     = 2'b00;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;

    if (!rst) begin
      timeout_hit = (state == BUSY) && (wait_cnt == LAST_WAIT) && !mdu_done;
      mdu_stall   = ((state == RUN) && mdu_start && !mdu_done) ||
                    ((state == BUSY) && !mdu_done && !timeout_hit);
      load_use    = (state == RUN) && !mdu_start && id_ex_mem_read &&
                    (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

      forward_a = fwd_sel(id_ex_rs1, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
      forward_b = fwd_sel(id_ex_rs2, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);

      case (state)
        RUN:     if (mdu_start && !mdu_done) state_nxt = BUSY;
        BUSY:    if (mdu_done || timeout_hit) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase

      // Freeze the front end and keep the MDU op in EX; EX/MEM gets NOPs.
      if (mdu_stall) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
      end else if (load_use) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_flush   = 1'b1;
      end
    end
  end

  assign mdu_busy     = (state == BUSY) && !rst;
  assign mdu_timeout  = timeout_q && !rst;
  assign stall_cycles = rst ? 32'd0 : stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == RUN)
        wait_cnt <= '0;
      else if (state_nxt == BUSY)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit)
        timeout_q <= 1'b1;
      if (!pc_write && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: a cycle-level reference model checked on
// every falling edge plus literal expectations at the interesting points.
module tb_ex_hazard_ctrl;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic        id_ex_mem_read;
  logic [4:0]  ex_mem_rd, mem_wb_rd;
  logic        ex_mem_reg_write, mem_wb_reg_write;
  logic        mdu_start, mdu_done;
  logic [1:0]  forward_a, forward_b;
  logic        pc_write, if_id_write, id_ex_write, id_ex_flush, ex_mem_bubble;
  logic        mdu_busy, mdu_timeout;
  logic [31:0] stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  ex_hazard_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .forward_a(forward_a), .forward_b(forward_b),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .mdu_busy(mdu_busy), .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit    m_busy = 0;      // an MDU op has been accepted and not finished
  int    m_waited = 0;    // BUSY cycles already spent before this one
  bit    m_to = 0;
  longint m_sc = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == rs) return 2'b10;
    if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    bit give_up, hold, bubble_ld, e_pc, e_idex, e_flush, e_bub;
    logic [1:0] e_fa, e_fb;
    if (rst) begin
      e_fa = 0; e_fb = 0; e_pc = 1; e_idex = 1; e_flush = 0; e_bub = 0;
      chk("fwd_a", forward_a, e_fa);
      chk("fwd_b", forward_b, e_fb);
      chk("pc_write", pc_write, e_pc);
      chk("if_id_write", if_id_write, e_pc);
      chk("id_ex_write", id_ex_write, e_idex);
      chk("id_ex_flush", id_ex_flush, e_flush);
      chk("ex_mem_bubble", ex_mem_bubble, e_bub);
      chk("mdu_busy", mdu_busy, 0);
      chk("mdu_timeout", mdu_timeout, 0);
      chk("stall_cycles", stall_cycles, 0);
      m_busy = 0; m_waited = 0; m_to = 0; m_sc = 0;
    end else begin
      give_up   = m_busy && !mdu_done && (m_waited + 1 >= MW);
      hold      = m_busy ? (!mdu_done && !give_up) : (mdu_start && !mdu_done);
      bubble_ld = !m_busy && !mdu_start && id_ex_mem_read && id_ex_rd != 0 &&
                  (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
      e_fa = ref_fwd(id_ex_rs1);
      e_fb = ref_fwd(id_ex_rs2);
      e_pc    = !(hold || bubble_ld);
      e_idex  = !hold;
      e_flush = !hold && bubble_ld;
      e_bub   = hold;
      chk("fwd_a", forward_a, e_fa);
      chk("fwd_b", forward_b, e_fb);
      chk("pc_write", pc_write, e_pc);
      chk("if_id_write", if_id_write, e_pc);
      chk("id_ex_write", id_ex_write, e_idex);
      chk("id_ex_flush", id_ex_flush, e_flush);
      chk("ex_mem_bubble", ex_mem_bubble, e_bub);
      chk("mdu_busy", mdu_busy, m_busy);
      chk("mdu_timeout", mdu_timeout, m_to);
      chk("stall_cycles", stall_cycles, m_sc[31:0]);
      if (!e_pc && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (give_up) m_to = 1;
      if (m_busy) begin
        if (mdu_done || give_up) begin m_busy = 0; m_waited = 0; end
        else m_waited++;
      end else if (mdu_start && !mdu_done) begin
        m_busy = 1; m_waited = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    if_id_rs1 = 0; if_id_rs2 = 0; id_ex_rs1 = 0; id_ex_rs2 = 0; id_ex_rd = 0;
    id_ex_mem_read = 0; ex_mem_rd = 0; ex_mem_reg_write = 0;
    mem_wb_rd = 0; mem_wb_reg_write = 0; mdu_start = 0; mdu_done = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    // Reset must mask an obvious forwarding match.
    id_ex_rs1 = 5; ex_mem_rd = 5; ex_mem_reg_write = 1;
    #2;
    chk("rst_fwd_a", forward_a, 2'b00);
    chk("rst_pc_write", pc_write, 1);
    tick(); tick();
    rst = 0;

    // Forwarding priority
    id_ex_rs1 = 5; ex_mem_rd = 5; ex_mem_reg_write = 1; mem_wb_rd = 5; mem_wb_reg_write = 1;
    #2; chk("fwd_exmem", forward_a, 2'b10); tick();
    ex_mem_reg_write = 0;
    #2; chk("fwd_memwb", forward_a, 2'b01); tick();
    ex_mem_reg_write = 1; ex_mem_rd = 0; mem_wb_rd = 0;
    #2; chk("fwd_x0", forward_a, 2'b00); tick();
    id_ex_rs2 = 9; ex_mem_rd = 3; mem_wb_rd = 9;
    #2; chk("fwd_b_memwb", forward_b, 2'b01); tick();

    // Load-use: one bubble
    idle_inputs();
    id_ex_mem_read = 1; id_ex_rd = 7; if_id_rs2 = 7;
    #2; chk("lu_pc_write", pc_write, 0); chk("lu_flush", id_ex_flush, 1); tick();
    idle_inputs();
    #2; chk("lu_stall_cnt", stall_cycles, 1);
    id_ex_mem_read = 1; id_ex_rd = 0; if_id_rs1 = 0; tick();
    idle_inputs(); tick();

    // MDU op, done arrives after three stalled BUSY cycles
    mdu_start = 1;
    #2; chk("mdu_start_stall", pc_write, 0); tick();
    id_ex_rs1 = 4; ex_mem_rd = 4; ex_mem_reg_write = 1;
    id_ex_mem_read = 1; id_ex_rd = 2; if_id_rs1 = 2;
    #2; chk("busy_fwd", forward_a, 2'b10); chk("busy_flag", mdu_busy, 1); tick();
    idle_inputs(); mdu_start = 1; tick();
    tick();
    mdu_done = 1;
    #2; chk("done_release", pc_write, 1); tick();
    idle_inputs();
    #2; chk("mdu_back_run", mdu_busy, 0); chk("mdu_stall_cnt", stall_cycles, 5); tick();

    // start + done + load-use together: nothing stalls
    mdu_start = 1; mdu_done = 1; id_ex_mem_read = 1; id_ex_rd = 3; if_id_rs1 = 3;
    #2; chk("coinc_pc_write", pc_write, 1); chk("coinc_flush", id_ex_flush, 0); tick();
    idle_inputs();
    #2; chk("coinc_run", mdu_busy, 0); tick();

    // Timeout with MAX_WAIT=4
    mdu_start = 1;
    tick(); tick(); tick(); tick();
    #2; chk("to_release", pc_write, 1); chk("to_busy_last", mdu_busy, 1); tick();
    mdu_start = 0;
    #2; chk("to_flag", mdu_timeout, 1); chk("to_run", mdu_busy, 0);
    chk("to_stall_cnt", stall_cycles, 9); tick();
    tick(); tick();
    #2; chk("to_sticky", mdu_timeout, 1);

    // Reset in the middle of BUSY
    mdu_start = 1; tick(); tick();
    rst = 1;
    #2; chk("rst_busy_out", mdu_busy, 0); chk("rst_bubble", ex_mem_bubble, 0); tick();
    rst = 0; idle_inputs();
    #2; chk("post_rst_busy", mdu_busy, 0); chk("post_rst_to", mdu_timeout, 0);
    chk("post_rst_cnt", stall_cycles, 0); tick();

    // done on the cycle the timeout would fire is a normal finish
    mdu_start = 1; tick(); tick(); tick(); tick();
    mdu_done = 1;
    #2; chk("late_done_pc", pc_write, 1); tick();
    idle_inputs();
    #2; chk("late_done_no_to", mdu_timeout, 0); chk("late_done_cnt", stall_cycles, 4); tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
